// File: rtl/iobuf_ctrl.sv
// iobuf_ctrl: half-duplex sequencer for a tristate bus built from iobuf cells.
// Turns a write stream and read requests into drive, release, turnaround and sample cycles.
module iobuf_ctrl #(
  parameter int WIDTH      = 16,
  parameter int RD_LATENCY = 2,
  parameter int TURNAROUND = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             buf_en,
  output logic [WIDTH-1:0] buf_i,
  input  logic [WIDTH-1:0] buf_o,
  output logic             busy
);

  localparam int CNT_MAX = (RD_LATENCY > TURNAROUND) ? RD_LATENCY : TURNAROUND;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RD_LOAD   = CW'(RD_LATENCY - 1);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURNAROUND - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CAPTURE,
    TURN
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             buf_en_reg, buf_en_next;
  logic [WIDTH-1:0] buf_i_reg, buf_i_next;
  logic             rd_valid_reg, rd_valid_next;
  logic [WIDTH-1:0] rd_data_reg, rd_data_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      buf_en_reg   <= 1'b1;
      buf_i_reg    <= '0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      buf_en_reg   <= buf_en_next;
      buf_i_reg    <= buf_i_next;
      rd_valid_reg <= rd_valid_next;
      rd_data_reg  <= rd_data_next;
    end
  end

  // buf_en_next defaults to released, so only a write accept can ever pull it low.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    buf_en_next   = 1'b1;
    buf_i_next    = buf_i_reg;
    rd_valid_next = 1'b0;
    rd_data_next  = rd_data_reg;
    wr_ready      = 1'b0;
    rd_ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        wr_ready = 1'b1;
        rd_ready = !wr_valid;
        if (wr_valid) begin
          state_next  = DRIVE;
          buf_en_next = 1'b0;
          buf_i_next  = wr_data;
        end else if (rd_req) begin
          state_next = WAIT;
          cnt_next   = RD_LOAD;
        end
      end
      DRIVE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          buf_en_next = 1'b0;
          buf_i_next  = wr_data;
        end else begin
          state_next = TURN;
          cnt_next   = TURN_LOAD;
        end
      end
      WAIT: begin
        // The pin is sampled on the edge leaving WAIT so rd_valid is high during CAPTURE.
        if (cnt_reg == '0) begin
          state_next    = CAPTURE;
          rd_data_next  = buf_o;
          rd_valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      CAPTURE: begin
        state_next = TURN;
        cnt_next   = TURN_LOAD;
      end
      TURN: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign buf_en   = buf_en_reg;
  assign buf_i    = buf_i_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;

endmodule
